multi_chan_fifo: RTL and testbench



---
 rtl/multi_chan_fifo_if.sv | 33 +++
 rtl/multi_chan_fifo.sv | 99 +++++++++
 tb/tb_multi_chan_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multi_chan_fifo_if.sv
// Bus interface for multi_chan_fifo: packed per-channel write/read handshake,
// read data and status. master = producer/consumer side, slave = FIFO bank.
interface multi_chan_fifo_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        i_push;
  logic [N_CH-1:0]        i_pop;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        is_full;
  logic [N_CH-1:0]        is_empty;
  logic [N_CH-1:0]        almost_full;
  logic [N_CH*CNT_W-1:0]  count;
  logic [N_CH-1:0]        err_ovf;
  logic [N_CH-1:0]        err_udf;

  modport master (
    output in_data, i_push, i_pop,
    input  out_data, out_valid, is_full, is_empty, almost_full, count,
           err_ovf, err_udf
  );

  modport slave (
    input  in_data, i_push, i_pop,
    output out_data, out_valid, is_full, is_empty, almost_full, count,
           err_ovf, err_udf
  );
endinterface

// File: rtl/multi_chan_fifo.sv
// multi_chan_fifo: N_CH independent synchronous circular-buffer FIFOs with
// occupancy count, almost-full threshold and registered read data + valid.
// Optional macro MCF_ERR_FLAG_EN enables sticky overflow/underflow flags;
// without it err_ovf/err_udf are tied low.
module multi_chan_fifo #(
  parameter  int N_CH      = 4,
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 8,
  parameter  int AF_THRESH = 6,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst,
  multi_chan_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic              pop_ok;

    assign push = bus.i_push[i];
    assign pop  = bus.i_pop[i];

    // Pop is judged on the pre-edge count; a push into a full FIFO is
    // accepted only when a pop frees a slot in the same cycle.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != CNT_W'(DEPTH)) || pop_ok);

    // Storage write; contents are not cleared by reset.
    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.in_data[i*DATA_W +: DATA_W];
      end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt      <= '0;
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= pop_ok;
        if (push_ok) begin
          wr_ptr <= PTR_W'(wr_ptr + 1'b1);
        end
        if (pop_ok) begin
          rd_data <= mem[rd_ptr];
          rd_ptr  <= PTR_W'(rd_ptr + 1'b1);
        end
        case ({push_ok, pop_ok})
          2'b10:   cnt <= CNT_W'(cnt + 1'b1);
          2'b01:   cnt <= CNT_W'(cnt - 1'b1);
          default: cnt <= cnt;
        endcase
      end
    end

    assign bus.out_data[i*DATA_W +: DATA_W] = rd_data;
    assign bus.out_valid[i]                 = rd_valid;
    assign bus.count[i*CNT_W +: CNT_W]      = cnt;
    assign bus.is_full[i]                   = (cnt == CNT_W'(DEPTH));
    assign bus.is_empty[i]                  = (cnt == '0);
    assign bus.almost_full[i]               = (cnt >= CNT_W'(AF_THRESH));

`ifdef MCF_ERR_FLAG_EN
    logic ovf;
    logic udf;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (push && !push_ok) ovf <= 1'b1;
        if (pop && !pop_ok)   udf <= 1'b1;
      end
    end

    assign bus.err_ovf[i] = ovf;
    assign bus.err_udf[i] = udf;
`else
    assign bus.err_ovf[i] = 1'b0;
    assign bus.err_udf[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_multi_chan_fifo.sv
// Testbench for multi_chan_fifo: directed scenarios plus randomized traffic,
// checked every cycle against per-channel queue models.
module tb_multi_chan_fifo;
  localparam int N_CH      = 4;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 6;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_chan_fifo_if #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  multi_chan_fifo #(
    .N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per channel plus last-read and sticky state.
  logic [DATA_W-1:0] q [N_CH][$];
  logic [DATA_W-1:0] exp_out   [N_CH];
  logic              exp_valid [N_CH];
  logic              exp_ovf   [N_CH];
  logic              exp_udf   [N_CH];

  task automatic check(input string tag, input int ch,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      q[ch].delete();
      exp_out[ch]   = '0;
      exp_valid[ch] = 1'b0;
      exp_ovf[ch]   = 1'b0;
      exp_udf[ch]   = 1'b0;
    end
  endtask

  task automatic model_clock(input logic [N_CH-1:0] push, input logic [N_CH-1:0] pop,
                             input logic [N_CH*DATA_W-1:0] din);
    for (int ch = 0; ch < N_CH; ch++) begin
      bit pop_ok, push_ok;
      pop_ok  = pop[ch] && (q[ch].size() > 0);
      push_ok = push[ch] && ((q[ch].size() < DEPTH) || pop_ok);
      exp_valid[ch] = pop_ok;
      if (pop_ok) exp_out[ch] = q[ch].pop_front();
      if (push_ok) q[ch].push_back(din[ch*DATA_W +: DATA_W]);
      if (push[ch] && !push_ok) exp_ovf[ch] = 1'b1;
      if (pop[ch] && !pop_ok)   exp_udf[ch] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int ch = 0; ch < N_CH; ch++) begin
      int n;
      n = q[ch].size();
      check("count",       ch, 32'(bus.count[ch*CNT_W +: CNT_W]), 32'(n));
      check("is_full",     ch, 32'(bus.is_full[ch]),     32'(n == DEPTH));
      check("is_empty",    ch, 32'(bus.is_empty[ch]),    32'(n == 0));
      check("almost_full", ch, 32'(bus.almost_full[ch]), 32'(n >= AF_THRESH));
      check("out_valid",   ch, 32'(bus.out_valid[ch]),   32'(exp_valid[ch]));
      check("out_data",    ch, 32'(bus.out_data[ch*DATA_W +: DATA_W]), 32'(exp_out[ch]));
`ifdef MCF_ERR_FLAG_EN
      check("err_ovf",     ch, 32'(bus.err_ovf[ch]), 32'(exp_ovf[ch]));
      check("err_udf",     ch, 32'(bus.err_udf[ch]), 32'(exp_udf[ch]));
`else
      check("err_ovf",     ch, 32'(bus.err_ovf[ch]), 32'd0);
      check("err_udf",     ch, 32'(bus.err_udf[ch]), 32'd0);
`endif
    end
  endtask

  // One clock of stimulus: drive, let the edge happen, update model, check.
  task automatic step(input logic [N_CH-1:0] push, input logic [N_CH-1:0] pop,
                      input logic [N_CH*DATA_W-1:0] din);
    bus.i_push  = push;
    bus.i_pop   = pop;
    bus.in_data = din;
    @(posedge clk);
    model_clock(push, pop, din);
    #1;
    check_all();
    bus.i_push = '0;
    bus.i_pop  = '0;
  endtask

  function automatic logic [N_CH*DATA_W-1:0] rand_data();
    logic [N_CH*DATA_W-1:0] d;
    for (int ch = 0; ch < N_CH; ch++) d[ch*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  // Single-channel operation; other lanes carry random data with no request.
  task automatic op1(input int ch, input bit push, input bit pop, input logic [DATA_W-1:0] d);
    logic [N_CH*DATA_W-1:0] din;
    logic [N_CH-1:0] pu, po;
    din = rand_data();
    din[ch*DATA_W +: DATA_W] = d;
    pu = '0;
    po = '0;
    pu[ch] = push;
    po[ch] = pop;
    step(pu, po, din);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_push  = '0;
    bus.i_pop   = '0;
    bus.in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // ch0: fill with 1..8, then drain in order.
    for (int k = 1; k <= 8; k++) op1(0, 1'b1, 1'b0, DATA_W'(k));
    for (int k = 0; k < 8; k++)  op1(0, 1'b0, 1'b1, '0);

    // ch1: full, simultaneous push 0xBEEF and pop, then drain.
    for (int k = 0; k < 8; k++) op1(1, 1'b1, 1'b0, DATA_W'($urandom));
    op1(1, 1'b1, 1'b1, 16'hBEEF);
    for (int k = 0; k < 8; k++) op1(1, 1'b0, 1'b1, '0);

    // ch2: empty, simultaneous push 0x1234 and pop, then pop.
    op1(2, 1'b1, 1'b1, 16'h1234);
    op1(2, 1'b0, 1'b1, '0);

    // ch3: full, push 0xDEAD without pop, then drain.
    for (int k = 0; k < 8; k++) op1(3, 1'b1, 1'b0, DATA_W'($urandom_range(16'hDEAC)));
    op1(3, 1'b1, 1'b0, 16'hDEAD);
    for (int k = 0; k < 8; k++) op1(3, 1'b0, 1'b1, '0);

    // ch0 pointer wrap with concurrent random traffic on ch1.
    for (int k = 0; k < 3; k++) op1(0, 1'b1, 1'b0, DATA_W'($urandom));
    for (int k = 0; k < 20; k++) begin
      logic [N_CH-1:0] pu, po;
      pu = 4'b0001;
      po = 4'b0001;
      pu[1] = 1'($urandom);
      po[1] = 1'($urandom);
      step(pu, po, rand_data());
    end
    for (int k = 0; k < 3; k++) op1(0, 1'b0, 1'b1, '0);

    // Randomized traffic on all channels with varying push/pop bias.
    for (int ph = 0; ph < 4; ph++) begin
      int pp, qp;
      pp = (ph == 0) ? 80 : (ph == 1) ? 50 : (ph == 2) ? 20 : 60;
      qp = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 80 : 60;
      for (int k = 0; k < 60; k++) begin
        logic [N_CH-1:0] pu, po;
        for (int ch = 0; ch < N_CH; ch++) begin
          pu[ch] = ($urandom_range(99) < pp);
          po[ch] = ($urandom_range(99) < qp);
        end
        step(pu, po, rand_data());
      end
    end

    // Drain ch0, load 5 entries, then assert reset between clock edges.
    for (int k = 0; k < DEPTH; k++) op1(0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 5; k++) op1(0, 1'b1, 1'b0, DATA_W'($urandom));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    op1(0, 1'b1, 1'b0, 16'hA5A5);
    op1(0, 1'b0, 1'b1, '0);
    op1(0, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
